// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a runtime-reloadable pattern, selectable overlap mode,
// a registered one-cycle match pulse and a saturating match counter.
module seq_detector_param #(
  parameter int                LEN     = 4,
  parameter logic [LEN-1:0]    PATTERN = 4'b1101,
  parameter int                CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i,
  input  logic                       i_valid,
  input  logic                       cfg_load,
  input  logic [LEN-1:0]             cfg_pattern,
  input  logic                       overlap_en,
  input  logic                       cnt_clr,
  output logic                       out,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [$clog2(LEN+1)-1:0]   fill
);

  localparam int                  FILL_W    = $clog2(LEN+1);
  localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(LEN);
  localparam logic [FILL_W-1:0]   FILL_THR  = FILL_W'(LEN-1);
  localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};

  logic [LEN-1:0]    pat;
  logic [LEN-1:0]    hist;
  logic [LEN-1:0]    window;
  logic              accept;
  logic              hit;
  logic [FILL_W-1:0] fill_next;

  // The window is what the history would become if this edge accepts i.
  always_comb begin
    window    = {hist[LEN-2:0], i};
    accept    = i_valid && !cfg_load;
    hit       = accept && (window == pat) && (fill >= FILL_THR);
    fill_next = fill;
    if (hit) begin
      fill_next = overlap_en ? FILL_FULL : '0;
    end else if (fill != FILL_FULL) begin
      fill_next = fill + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat  <= PATTERN;
      hist <= '0;
      fill <= '0;
      out  <= 1'b0;
    end else if (cfg_load) begin
      pat  <= cfg_pattern;
      hist <= '0;
      fill <= '0;
      out  <= 1'b0;
    end else if (i_valid) begin
      hist <= window;
      fill <= fill_next;
      out  <= hit;
    end else begin
      out  <= 1'b0;
    end
  end

  // Clear beats a coincident hit; the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      match_cnt <= '0;
    end else if (hit && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: an 8-bit-counter instance plus a 2-bit-counter
// instance sharing the same stimulus, so counter saturation can be observed quickly.
module tb_seq_detector_param;

  logic       clk;
  logic       rst;
  logic       i;
  logic       i_valid;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic       overlap_en;
  logic       cnt_clr;
  logic       out;
  logic [7:0] match_cnt;
  logic [2:0] fill;
  logic       out2;
  logic [1:0] match_cnt2;
  logic [2:0] fill2;

  int checks = 0;
  int errors = 0;

  seq_detector_param #(.LEN(4), .PATTERN(4'b1101), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .out(out), .match_cnt(match_cnt), .fill(fill)
  );

  seq_detector_param #(.LEN(4), .PATTERN(4'b1101), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .out(out2), .match_cnt(match_cnt2), .fill(fill2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one clock cycle of inputs on the falling edge; outputs are readable on return.
  task automatic step(input logic v, input logic b, input logic ld, input logic clr,
                      input logic r);
    @(negedge clk);
    i_valid  = v;
    i        = b;
    cfg_load = ld;
    cnt_clr  = clr;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic bit_in(input logic b);
    step(1'b1, b, 1'b0, 1'b0, 1'b0);
  endtask

  logic [6:0] stream7;
  logic [6:0] exp_ov;
  logic [6:0] exp_nov;
  logic [3:0] nib;

  initial begin
    rst = 1'b1; i = 1'b0; i_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 4'b0000; overlap_en = 1'b1; cnt_clr = 1'b0;
    stream7 = 7'b1101101;
    exp_ov  = 7'b0001001;
    exp_nov = 7'b0001000;

    do_reset();
    check("reset_out", out, 0);
    check("reset_cnt", match_cnt, 0);
    check("reset_fill", fill, 0);

    // 1: overlapping stream
    overlap_en = 1'b1;
    for (int k = 6; k >= 0; k--) begin
      bit_in(stream7[k]);
      check($sformatf("t1_out_bit%0d", 7 - k), out, exp_ov[k]);
    end
    check("t1_cnt", match_cnt, 2);
    check("t1_fill", fill, 4);

    // 2: non-overlapping stream
    do_reset();
    overlap_en = 1'b0;
    for (int k = 6; k >= 0; k--) begin
      bit_in(stream7[k]);
      check($sformatf("t2_out_bit%0d", 7 - k), out, exp_nov[k]);
    end
    check("t2_cnt", match_cnt, 1);
    check("t2_fill", fill, 3);

    // 3: idle gap inside a sequence
    do_reset();
    overlap_en = 1'b1;
    bit_in(1'b1);
    bit_in(1'b1);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t3_gap_fill", fill, 2);
      check("t3_gap_out", out, 0);
    end
    bit_in(1'b0);
    check("t3_out_bit3", out, 0);
    bit_in(1'b1);
    check("t3_out_bit4", out, 1);
    check("t3_cnt", match_cnt, 1);

    // 4: pattern reload with a coincident valid bit
    do_reset();
    cfg_pattern = 4'b0110;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t4_load_fill", fill, 0);
    check("t4_load_out", out, 0);
    bit_in(1'b1);
    check("t4_first_fill", fill, 1);
    nib = 4'b1101;
    for (int k = 3; k >= 0; k--) begin
      if (k < 3) bit_in(nib[k]);
      check("t4_old_pat_out", out, 0);
    end
    nib = 4'b0110;
    for (int k = 3; k >= 0; k--) begin
      bit_in(nib[k]);
      check($sformatf("t4_new_pat_bit%0d", 4 - k), out, (k == 0) ? 1 : 0);
    end
    check("t4_cnt", match_cnt, 1);

    // 5: counter saturation and clear on a hit edge
    do_reset();
    overlap_en = 1'b1;
    nib = 4'b1101;
    for (int r = 0; r < 5; r++) begin
      for (int k = 3; k >= 0; k--) begin
        bit_in(nib[k]);
        check("t5_out", out2, (k == 0) ? 1 : 0);
      end
    end
    check("t5_cnt_w2_sat", match_cnt2, 3);
    check("t5_cnt_w8", match_cnt, 5);
    bit_in(1'b1);
    bit_in(1'b1);
    bit_in(1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t5_clr_out", out2, 1);
    check("t5_clr_cnt_w2", match_cnt2, 0);
    check("t5_clr_cnt_w8", match_cnt, 0);

    // 6: reset mid-sequence, with a valid bit offered during reset
    do_reset();
    bit_in(1'b1);
    bit_in(1'b1);
    bit_in(1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t6_rst_out", out, 0);
    check("t6_rst_fill", fill, 0);
    bit_in(1'b1);
    check("t6_after_out", out, 0);
    check("t6_after_fill", fill, 1);
    check("t6_after_cnt", match_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
